// File: rtl/fetch_decode.sv
// fetch_decode: byte-wide fetch / decode / execute sequencer driving an external 2-bit ALU.
// Instruction format: opcode[7:5], imm[4:3], rb[2:1], bit 0 unused.
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [2:0] alu_sel,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  input  logic [1:0] alu_out,
  output logic [7:0] pc,
  output logic       halt,
  output logic [7:0] dbg_regs
);

  localparam int unsigned AW = 8;
  localparam int unsigned RW = 2;
  localparam int unsigned OW = 3;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [AW-1:0]       ir;
  logic [3:0][RW-1:0]  regs;

  logic [OW-1:0]       opcode;
  logic [RW-1:0]       imm;
  logic [1:0]          rb;
  logic [RW-1:0]       rb_val;
  logic [AW-1:0]       pc_inc;
  logic [AW-1:0]       pc_fwd;
  logic [AW-1:0]       pc_back;
  logic [AW-1:0]       exec_pc;
  logic                wr_en;
  logic                unused_ir0;

  assign opcode     = ir[7:5];
  assign imm        = ir[4:3];
  assign rb         = ir[2:1];
  assign rb_val     = regs[rb];
  assign unused_ir0 = ir[0];

  assign pc_inc  = pc + AW'(1);
  assign pc_fwd  = pc + AW'(imm);
  assign pc_back = pc - AW'(imm);

  // Fetch request only in FETCH, and never while reset is held.
  assign mem_req  = (state == S_FETCH) && !rst;
  assign mem_addr = pc;
  assign dbg_regs = regs;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ack) state_nx = S_DECODE;
      S_DECODE: state_nx = (opcode == 3'b111) ? S_HALT : S_EXEC;
      S_EXEC:   state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
    endcase
  end

  // Execute-stage result: next pc and whether the ALU result is written back.
  always_comb begin
    exec_pc = pc_inc;
    wr_en   = 1'b0;
    case (opcode)
      3'b000, 3'b001, 3'b010: wr_en = 1'b1;
      3'b011: if (rb_val == RW'(0)) exec_pc = pc_fwd;
      3'b100: if (rb_val == RW'(0)) exec_pc = pc_back;
      3'b101: exec_pc = pc_fwd;
      3'b110: exec_pc = pc_back;
      default: ;
    endcase
  end

  // Datapath registers: instruction capture, ALU operands, writeback, pc, halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      regs    <= '0;
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      halt    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) ir <= mem_data;
        end
        S_DECODE: begin
          alu_sel <= opcode;
          alu_a   <= imm;
          alu_b   <= rb_val;
          if (opcode == 3'b111) halt <= 1'b1;
        end
        S_EXEC: begin
          pc <= exec_pc;
          if (wr_en) regs[rb] <= alu_out;
        end
        S_HALT: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter: RESET_PC, 8'h00, program counter value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: mem_req  output  1  instruction fetch request.
REQ-005 SHALL have port: mem_addr  output  8  fetch address, equal to pc.
REQ-006 SHALL have port: mem_ack  input  1  fetch data valid this cycle.
REQ-007 SHALL have port: mem_data  input  8  instruction byte.
REQ-008 SHALL have port: alu_sel  output  3  ALU operation select.
REQ-009 SHALL have port: alu_a  output  2  ALU operand a (immediate).
REQ-010 SHALL have port: alu_b  output  2  ALU operand b (register value).
REQ-011 SHALL have port: alu_out  input  2  ALU combinational result.
REQ-012 SHALL have port: pc  output  8  program counter.
REQ-013 SHALL have port: halt  output  1  high once HALT executes.
REQ-014 SHALL have port: dbg_regs  output  8  {r3,r2,r1,r0}, internal 2-bit registers.

Function
REQ-015 SHALL decode instruction as opcode=[7:5], imm=[4:3], rb=[2:1]; bit 0 ignored.
REQ-016 SHALL hold four 2-bit registers r0..r3, all writable.
REQ-017 SHALL implement states FETCH, DECODE, EXEC, HALT; encoding free.
REQ-018 FETCH: mem_req=1, mem_addr=pc; stay while mem_ack=0; on posedge with mem_ack=1 capture mem_data, go DECODE.
REQ-019 mem_req SHALL be 0 in every state except FETCH; mem_addr SHALL remain stable while mem_req=1.
REQ-020 mem_ack outside FETCH SHALL be ignored.
REQ-021 DECODE (1 cycle): register alu_sel=opcode, alu_a=imm, alu_b=r[rb]; go EXEC, or HALT if opcode=3'b111.
REQ-022 EXEC (1 cycle): apply result per REQ-023..026 on its closing edge, go FETCH.
REQ-023 Opcodes 000/001/010: r[rb] <= alu_out (pass imm, r+imm, r-imm; mod 4 from ALU); pc <= pc+1.
REQ-024 Opcodes 011/100 (conditional): if r[rb]==0, pc <= pc+imm (011) or pc-imm (100); else pc <= pc+1.
REQ-025 Opcodes 101/110 (unconditional): pc <= pc+imm (101) or pc-imm (110); imm=0 leaves pc unchanged.
REQ-026 All pc arithmetic SHALL be unsigned 8-bit with wrap-around (0xFF+1=0x00, 0x00-1=0xFF); pc computed here, ALU pc output unused.
REQ-027 Jump/branch opcodes SHALL not write any register.
REQ-028 HALT: halt=1, mem_req=0, all state frozen until reset.
REQ-029 Minimum instruction latency SHALL be 3 cycles (ack in first FETCH cycle); each FETCH wait cycle adds one.
REQ-030 alu_sel/alu_a/alu_b SHALL hold their last values outside DECODE/EXEC.

Reset
REQ-031 Asserting rst SHALL immediately force: state=FETCH, pc=RESET_PC, r0..r3=0, alu_sel=0, alu_a=0, alu_b=0, halt=0, instruction register=0.
REQ-032 mem_req SHALL be 0 while rst=1, regardless of state; first fetch request at first posedge after rst deasserts.
REQ-033 Reset mid-fetch or mid-EXEC SHALL discard the pending instruction with no register or pc update.

Verification
REQ-034 Reset: rst=1 mid-EXEC -> pc=0x00, dbg_regs=0x00, halt=0, mem_req=0 without clock edge; release -> mem_req=1, mem_addr=0x00.
REQ-035 Pass/add wrap: mem[0]=0x1A, mem[1]=0x32, zero-wait ack -> after 3 cycles dbg_regs=0x0C (r1=3), after 6 cycles dbg_regs=0x04 (r1=1), pc=0x02.
REQ-036 Conditional jump: pc=0x05, r2=0, instr 0x7C -> pc=0x08; same with r2=1 -> pc=0x06, dbg_regs unchanged.
REQ-037 Jump-up wrap: pc=0x01, instr 0xD0 -> pc=0xFF; next mem_addr=0xFF.
REQ-038 Wait states: mem_ack delayed 3 cycles -> mem_req held 4 cycles, mem_addr stable, instruction completes in 6 cycles; stray mem_ack in DECODE has no effect.
REQ-039 Halt: instr 0xE0 -> halt=1 after DECODE, mem_req stays 0 and pc frozen for 20 cycles; rst clears halt.
